// File: rtl/code_checker.sv
// code_checker: receive-side checker for the dual 64-bit sequence stream.
// Channel 0 expects a +1 counter and channel 1 a Fibonacci sequence.
// Each channel acquires lock, flags mismatches while locked, and drops lock
// after MISS_LIMIT consecutive misses.
// Optional feature: define CODE_CHK_ERRCNT_EN to build the saturating ErrCnt
// counter. When it is undefined, ErrCnt is tied to zero.
module code_checker #(
    parameter int MISS_LIMIT = 3,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              Slt,
    input  logic [63:0]       Din,
    output logic              Locked0,
    output logic              Locked1,
    output logic              Err,
    output logic [CNT_W-1:0]  ErrCnt,
    output logic [63:0]       Expect
);

    typedef enum logic [1:0] {IDLE, ACQ1, ACQ2, LOCK} state_t;

    // Miss count at which the next miss forces the channel back to IDLE.
    localparam logic [3:0] LIMIT_M1 = 4'(MISS_LIMIT - 1);

    state_t      state0, state0_next;
    state_t      state1, state1_next;
    logic [63:0] c0_h1;
    logic [63:0] c1_h0, c1_h1;
    logic [3:0]  miss0, miss1;
    logic [63:0] exp0, exp1;
    logic        adv0, adv1;
    logic        hit0, hit1;
    logic        bad0, bad1;
    logic        drop0, drop1;

    // Next expected word of each channel, derived from its history.
    assign exp0  = c0_h1 + 64'd1;
    assign exp1  = c1_h0 + c1_h1;

    // Only the channel selected by Slt advances, and only on a valid word.
    assign adv0  = En && !Slt;
    assign adv1  = En && Slt;
    assign hit0  = (Din == exp0);
    assign hit1  = (Din == exp1);

    // A miss is only an error while locked. The last allowed miss drops lock.
    assign bad0  = adv0 && (state0 == LOCK) && !hit0;
    assign bad1  = adv1 && (state1 == LOCK) && !hit1;
    assign drop0 = bad0 && (miss0 == LIMIT_M1);
    assign drop1 = bad1 && (miss1 == LIMIT_M1);

    // State registers for both channel FSMs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state0 <= IDLE;
            state1 <= IDLE;
        end else begin
            state0 <= state0_next;
            state1 <= state1_next;
        end
    end

    // Channel 0 next state. It needs only one history word, so ACQ1 is skipped.
    always_comb begin
        state0_next = state0;
        if (adv0) begin
            case (state0)
                IDLE:    state0_next = ACQ2;
                ACQ2:    state0_next = hit0 ? LOCK : ACQ2;
                LOCK:    state0_next = drop0 ? IDLE : LOCK;
                default: state0_next = IDLE;
            endcase
        end
    end

    // Channel 1 next state. It needs two history words before it can compare.
    always_comb begin
        state1_next = state1;
        if (adv1) begin
            case (state1)
                IDLE:    state1_next = ACQ1;
                ACQ1:    state1_next = ACQ2;
                ACQ2:    state1_next = hit1 ? LOCK : ACQ2;
                LOCK:    state1_next = drop1 ? IDLE : LOCK;
                default: state1_next = IDLE;
            endcase
        end
    end

    // Lock indicators decoded from the registered FSM states.
    always_comb begin
        Locked0 = (state0 == LOCK);
        Locked1 = (state1 == LOCK);
    end

    // Channel 0 history and miss counter. While locked, a corrupted word is
    // replaced by the expected value so the channel keeps free-running.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            c0_h1 <= '0;
            miss0 <= '0;
        end else if (adv0) begin
            case (state0)
                LOCK: begin
                    if (hit0) begin
                        c0_h1 <= Din;
                        miss0 <= '0;
                    end else if (drop0) begin
                        c0_h1 <= '0;
                        miss0 <= '0;
                    end else begin
                        c0_h1 <= exp0;
                        miss0 <= miss0 + 4'd1;
                    end
                end
                default: c0_h1 <= Din;
            endcase
        end
    end

    // Channel 1 history shift and miss counter, with the same substitution
    // of the expected value on a miss in LOCK.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            c1_h0 <= '0;
            c1_h1 <= '0;
            miss1 <= '0;
        end else if (adv1) begin
            case (state1)
                IDLE: c1_h0 <= Din;
                ACQ1: c1_h1 <= Din;
                ACQ2: begin
                    c1_h0 <= c1_h1;
                    c1_h1 <= Din;
                end
                LOCK: begin
                    if (hit1) begin
                        c1_h0 <= c1_h1;
                        c1_h1 <= Din;
                        miss1 <= '0;
                    end else if (drop1) begin
                        c1_h0 <= '0;
                        c1_h1 <= '0;
                        miss1 <= '0;
                    end else begin
                        c1_h0 <= c1_h1;
                        c1_h1 <= exp1;
                        miss1 <= miss1 + 4'd1;
                    end
                end
                default: c1_h0 <= Din;
            endcase
        end
    end

    // One-cycle error pulse following a mismatching sample in LOCK.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Err <= 1'b0;
        end else begin
            Err <= bad0 || bad1;
        end
    end

`ifdef CODE_CHK_ERRCNT_EN
    // Saturating total mismatch count. It holds at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ErrCnt <= '0;
        end else if ((bad0 || bad1) && (ErrCnt != '1)) begin
            ErrCnt <= ErrCnt + 1'b1;
        end
    end
`else
    assign ErrCnt = '0;
`endif

    // Expected word of whichever channel the current Slt addresses.
    always_comb begin
        Expect = Slt ? exp1 : exp0;
    end

endmodule
